// File: rtl/audio_sched.sv
// audio_sched: round-robin time-slot scheduler feeding the shared 1-bit audio DAC.
// Each source's latest sample is held, optionally attenuated by a per-source
// right shift, and presented to the DAC for one slot of 2^SLOTW clocks.
// Muted sources are skipped. If every source is muted, the DAC sees silence.
// Optional feature: define AUDIO_SCHED_ATTEN_EN to build the per-source
// attenuation registers and enable the cfg write port. Without it, the cfg
// inputs are ignored and samples pass through unshifted.
module audio_sched #(
    parameter int N     = 4,
    parameter int SLOTW = 1
) (
    input  logic           clock_i,
    input  logic           reset_i,
    input  logic [8*N-1:0] di_i,
    input  logic [N-1:0]   stb_i,
    input  logic [N-1:0]   mute_i,
    input  logic           cfg_we_i,
    input  logic [2:0]     cfg_addr_i,
    input  logic [2:0]     cfg_data_i,
    output logic [7:0]     dac_di_o,
    output logic           dac_load_o,
    output logic [2:0]     slot_o
);

    logic [SLOTW-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       dac_q, dac_d;
    logic             load_q, load_d;
    logic [7:0]       hold_q [N];

    logic             found;
    logic [2:0]       nxt;
    logic [3:0]       cand;
    logic             cand_mute;
    logic [7:0]       sel_hold;
    logic [7:0]       sel_samp;

    // Holding registers capture a source sample whenever its strobe is high.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < N; k++) hold_q[k] <= 8'h00;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (stb_i[k]) hold_q[k] <= di_i[8*k +: 8];
            end
        end
    end

`ifdef AUDIO_SCHED_ATTEN_EN
    logic [2:0] att_q [N];
    logic [2:0] sel_att;

    // Attenuation registers; addresses at or above N address nothing.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int k = 0; k < N; k++) att_q[k] <= 3'd0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (cfg_we_i && (cfg_addr_i == 3'(k))) att_q[k] <= cfg_data_i;
            end
        end
    end

    // Look up the attenuation of the source chosen for the next slot.
    always_comb begin
        sel_att = 3'd0;
        for (int k = 0; k < N; k++) begin
            if (nxt == 3'(k)) sel_att = att_q[k];
        end
        sel_samp = sel_hold >> sel_att;
    end
`else
    logic unused_cfg;
    assign unused_cfg = cfg_we_i ^ (^cfg_addr_i) ^ (^cfg_data_i);

    // Without attenuation, the held sample goes straight to the DAC.
    always_comb begin
        sel_samp = sel_hold;
    end
`endif

    // Pick the next unmuted source after idx; idx itself is the last candidate.
    always_comb begin
        found     = 1'b0;
        nxt       = idx_q;
        cand      = 4'd0;
        cand_mute = 1'b1;
        sel_hold  = 8'h00;
        for (int i = 1; i <= N; i++) begin
            cand = {1'b0, idx_q} + 4'(i);
            if (cand >= 4'(N)) cand = cand - 4'(N);
            cand_mute = 1'b1;
            for (int k = 0; k < N; k++) begin
                if (cand == 4'(k)) cand_mute = mute_i[k];
            end
            if (!found && !cand_mute) begin
                found = 1'b1;
                nxt   = cand[2:0];
            end
        end
        for (int k = 0; k < N; k++) begin
            if (nxt == 3'(k)) sel_hold = hold_q[k];
        end
    end

    // Slot timing: outputs only change on the edge where the counter is all-ones.
    always_comb begin
        cnt_d  = cnt_q + SLOTW'(1);
        idx_d  = idx_q;
        dac_d  = dac_q;
        load_d = 1'b0;
        if (cnt_q == '1) begin
            load_d = 1'b1;
            if (found) begin
                idx_d = nxt;
                dac_d = sel_samp;
            end else begin
                dac_d = 8'h00;
            end
        end
    end

    // Slot counter, active index and DAC output registers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q  <= '0;
            idx_q  <= 3'(N - 1);
            dac_q  <= 8'h00;
            load_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            dac_q  <= dac_d;
            load_q <= load_d;
        end
    end

    assign dac_di_o   = dac_q;
    assign dac_load_o = load_q;
    assign slot_o     = idx_q;

endmodule

// File: tb/tb_audio_sched.sv
// Testbench for audio_sched (N=4, SLOTW=1): directed scenarios followed by
// random traffic, all compared cycle by cycle against a behavioural model.
module tb_audio_sched;

    localparam int N     = 4;
    localparam int SLOTW = 1;
    localparam int SL    = 1 << SLOTW;

    logic           clock;
    logic           reset;
    logic [8*N-1:0] di;
    logic [N-1:0]   stb;
    logic [N-1:0]   mute;
    logic           cfg_we;
    logic [2:0]     cfg_addr;
    logic [2:0]     cfg_data;
    logic [7:0]     dac_di;
    logic           dac_load;
    logic [2:0]     slot;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    logic [7:0] m_hold [N];
    logic [2:0] m_att  [N];
    int         m_idx;
    logic [7:0] m_dac;
    logic       m_load;
    int         m_cyc;

    audio_sched #(.N(N), .SLOTW(SLOTW)) dut (
        .clock_i   (clock),
        .reset_i   (reset),
        .di_i      (di),
        .stb_i     (stb),
        .mute_i    (mute),
        .cfg_we_i  (cfg_we),
        .cfg_addr_i(cfg_addr),
        .cfg_data_i(cfg_data),
        .dac_di_o  (dac_di),
        .dac_load_o(dac_load),
        .slot_o    (slot)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_hold[k] = 8'h00;
            m_att[k]  = 3'd0;
        end
        m_idx  = N - 1;
        m_dac  = 8'h00;
        m_load = 1'b0;
        m_cyc  = 0;
    endtask

    // One clock edge as seen by the reference: slots are every SL clocks,
    // rotation is "next unmuted source after the current one, modulo N".
    task automatic model_edge();
        int nxt;
        if ((m_cyc % SL) == SL - 1) begin
            nxt = -1;
            for (int i = 1; i <= N; i++) begin
                int c;
                c = (m_idx + i) % N;
                if (nxt < 0 && !mute[c]) nxt = c;
            end
            m_load = 1'b1;
            if (nxt < 0) begin
                m_dac = 8'h00;
            end else begin
                m_idx = nxt;
`ifdef AUDIO_SCHED_ATTEN_EN
                m_dac = m_hold[nxt] >> m_att[nxt];
`else
                m_dac = m_hold[nxt];
`endif
            end
        end else begin
            m_load = 1'b0;
        end
        for (int k = 0; k < N; k++) begin
            if (stb[k]) m_hold[k] = di[8*k +: 8];
        end
`ifdef AUDIO_SCHED_ATTEN_EN
        if (cfg_we && int'(cfg_addr) < N) m_att[cfg_addr] = cfg_data;
`endif
        m_cyc++;
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, ".dac_di"}, 32'(dac_di), 32'(m_dac));
        check_eq({tag, ".dac_load"}, 32'(dac_load), 32'(m_load));
        check_eq({tag, ".slot"}, 32'(slot), 32'(m_idx));
    endtask

    task automatic step(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("reset");
        repeat (2) @(posedge clock);
        check_outputs("reset_hold");
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic clear_inputs();
        stb    = '0;
        cfg_we = 1'b0;
    endtask

    // Advance until the model has just loaded source s; bounded.
    task automatic run_to_slot(input int s, input string tag, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 4 * N * SL; t++) begin
            step(tag);
            if (m_load && m_idx == s) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        bit ok;
        logic [7:0] att_exp;
        reset    = 1'b0;
        di       = '0;
        stb      = '0;
        mute     = '0;
        cfg_we   = 1'b0;
        cfg_addr = 3'd0;
        cfg_data = 3'd0;
        model_reset();

        apply_reset();

        // Load 11,24,B8,C0 into sources 0..3
        for (int k = 0; k < N; k++) begin
            logic [31:0] vals;
            vals = 32'hC0B82411;
            stb = '0;
            stb[k] = 1'b1;
            di[8*k +: 8] = vals[8*k +: 8];
            step("load");
        end
        clear_inputs();

        // Plain rotation
        for (int t = 0; t < 12; t++) step("rot");
        run_to_slot(2, "rot_b8", ok);
        if (ok) begin
            att_exp = 8'hB8;
            check_eq("rot.src2", 32'(dac_di), 32'(att_exp));
        end

        // Sources 1 and 3 only
        mute = 4'b0101;
        for (int t = 0; t < 10; t++) step("mute0101");

        // Everything muted: silence, slot frozen, dac_load keeps pulsing
        mute = 4'b1111;
        for (int t = 0; t < 10; t++) step("muteall");
        mute = 4'b0000;

        // Attenuate source 2 by 3; write to an out-of-range address is dropped
        cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 3'd3;
        step("cfg2");
        cfg_addr = 3'd5; cfg_data = 3'd7;
        step("cfg5");
        cfg_we = 1'b0;
        run_to_slot(2, "att", ok);
        if (ok) begin
`ifdef AUDIO_SCHED_ATTEN_EN
            att_exp = 8'h17;
`else
            att_exp = 8'hB8;
`endif
            check_eq("att.src2", 32'(dac_di), 32'(att_exp));
        end

        // Strobe source 1 on the very edge that selects it
        ok = 1'b0;
        for (int t = 0; t < 4 * N * SL; t++) begin
            if ((m_cyc % SL) == SL - 1 && m_idx == 0) begin
                ok = 1'b1;
                break;
            end
            step("stb_seek");
        end
        if (!ok) check_eq("stb_seek.timeout", 32'd0, 32'd1);
        stb = 4'b0010;
        di[15:8] = 8'h55;
        step("stb_edge");
        att_exp = 8'h24;
        check_eq("stb_edge.old", 32'(dac_di), 32'(att_exp));
        clear_inputs();
        run_to_slot(1, "stb_next", ok);
        if (ok) begin
            att_exp = 8'h55;
            check_eq("stb_next.new", 32'(dac_di), 32'(att_exp));
        end

        // Reset in the middle of a slot
        step("pre_rst");
        #2;
        apply_reset();
        step("post_rst1");
        check_eq("post_rst1.load", 32'(dac_load), 32'd0);
        step("post_rst2");
        check_eq("post_rst2.load", 32'(dac_load), 32'd1);
        check_eq("post_rst2.slot", 32'(slot), 32'd0);

        // Random traffic
        for (int t = 0; t < 3000; t++) begin
            stb = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            di  = 8*N'($urandom);
            if ((t % 40) == 0) begin
                case ($urandom_range(0, 3))
                    0:       mute = '0;
                    1:       mute = '1;
                    default: mute = N'($urandom);
                endcase
            end
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_addr = 3'($urandom);
            cfg_data = 3'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #($urandom_range(1, 3));
                apply_reset();
            end else begin
                step("rand");
            end
        end
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
